bbox_tracker: RTL and testbench

Parametrised single-object bounding-box tracker for the binary-image video path. It sits after the binarisation stage and before the display/overlay sink. For each frame it finds the true min/max extent of all foreground pixels, their count, and the box area and centre. It publishes the results once per frame with a valid strobe, and draws the previous frame's box and/or centre onto the passing video in a run-time selectable mode.

---
 rtl/bbox_pkg.sv | 16 +
 rtl/bbox_raster_cnt.sv | 61 ++++++
 rtl/bbox_tracker.sv | 259 +++++++++++++++++++++++++
 tb/tb_bbox_tracker.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box tracker.
package bbox_pkg;

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_ACCUM   = 2'd1,
        S_RESOLVE = 2'd2,
        S_PUBLISH = 2'd3
    } state_e;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_BOX  = 2'd1;
    localparam logic [1:0] MODE_BOXC = 2'd2;
    localparam logic [1:0] MODE_CTR  = 2'd3;

endpackage

// File: rtl/bbox_raster_cnt.sv
// Raster position counters with frame-start (vsync rise) and frame-end
// (last active pixel) strobes; o_hcnt/o_vcnt give the position of the current pixel.
module bbox_raster_cnt #(
    parameter int IMG_W = 200,
    parameter int IMG_H = 164,
    parameter int CW    = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vsync,
    input  logic          i_de,
    output logic [CW-1:0] o_hcnt,
    output logic [CW-1:0] o_vcnt,
    output logic          o_frame_start,
    output logic          o_frame_end
);

    localparam logic [CW-1:0] H_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] V_LAST = CW'(IMG_H - 1);

    logic          vsync_q;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          h_last, v_last;

    always_comb begin
        h_last        = (hcnt_q == H_LAST);
        v_last        = (vcnt_q == V_LAST);
        o_frame_start = i_vsync & ~vsync_q;
        o_frame_end   = i_de & h_last & v_last;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        if (o_frame_start) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (i_de) begin
            if (h_last) begin
                hcnt_d = '0;
                vcnt_d = v_last ? '0 : vcnt_q + CW'(1);
            end else begin
                hcnt_d = hcnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            vsync_q <= i_vsync;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

    assign o_hcnt = hcnt_q;
    assign o_vcnt = vcnt_q;

endmodule

// File: rtl/bbox_tracker.sv
// Single-object bounding-box tracker: per-frame extent, count, area and centre of
// foreground pixels, published once per frame and drawn onto the following frame.
//
// state     | meaning
// S_WAIT    | idle, pixels ignored until vsync rise
// S_ACCUM   | accumulating foreground extent and count
// S_RESOLVE | derive found flag, centre and area
// S_PUBLISH | load outputs, pulse o_valid, clear accumulators
module bbox_tracker
    import bbox_pkg::*;
#(
    parameter int            IMG_W     = 200,
    parameter int            IMG_H     = 164,
    parameter int            DW        = 24,
    parameter int            CW        = 11,
    parameter logic [DW-1:0] FG_VAL    = 24'h000000,
    parameter int            MIN_PIX   = 500,
    parameter logic [DW-1:0] BOX_COLOR = 24'hff0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   i_data,
    input  logic            i_hsync,
    input  logic            i_vsync,
    input  logic            i_de,
    input  logic [1:0]      i_mode,
    output logic [DW-1:0]   o_data,
    output logic            o_hsync,
    output logic            o_vsync,
    output logic            o_de,
    output logic            o_valid,
    output logic            o_found,
    output logic [CW-1:0]   o_x0,
    output logic [CW-1:0]   o_y0,
    output logic [CW-1:0]   o_x1,
    output logic [CW-1:0]   o_y1,
    output logic [CW-1:0]   o_mid_x,
    output logic [CW-1:0]   o_mid_y,
    output logic [2*CW-1:0] o_area,
    output logic [2*CW-1:0] o_fg_count
);

    localparam logic [2*CW-1:0] MIN_CNT = (2*CW)'(MIN_PIX);

    logic [CW-1:0] hcnt, vcnt;
    logic          frame_start, frame_end;

    bbox_raster_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW)) u_raster (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_vsync       (i_vsync),
        .i_de          (i_de),
        .o_hcnt        (hcnt),
        .o_vcnt        (vcnt),
        .o_frame_start (frame_start),
        .o_frame_end   (frame_end)
    );

    state_e          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [2*CW-1:0] fg_cnt_q, fg_cnt_d;
    logic [CW-1:0]   xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic            res_found_q, res_found_d;
    logic [CW-1:0]   res_mid_x_q, res_mid_x_d, res_mid_y_q, res_mid_y_d;
    logic [2*CW-1:0] res_area_q, res_area_d;
    logic            valid_q, valid_d, found_q, found_d;
    logic [CW-1:0]   x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [CW-1:0]   mid_x_q, mid_x_d, mid_y_q, mid_y_d;
    logic [2*CW-1:0] area_q, area_d, fg_count_q, fg_count_d;
    logic [DW-1:0]   data_q, data_d;
    logic            hsync_q, vsync_q, de_q;

    logic          is_fg;
    logic [CW:0]   sum_x, sum_y;
    logic [CW-1:0] len_x, len_y;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        fg_cnt_d    = fg_cnt_q;
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymin_d      = ymin_q;
        ymax_d      = ymax_q;
        res_found_d = res_found_q;
        res_mid_x_d = res_mid_x_q;
        res_mid_y_d = res_mid_y_q;
        res_area_d  = res_area_q;
        valid_d     = 1'b0;
        found_d     = found_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        mid_x_d     = mid_x_q;
        mid_y_d     = mid_y_q;
        area_d      = area_q;
        fg_count_d  = fg_count_q;

        is_fg = i_de && (i_data == FG_VAL);
        sum_x = {1'b0, xmin_q} + {1'b0, xmax_q};
        sum_y = {1'b0, ymin_q} + {1'b0, ymax_q};
        len_x = xmax_q - xmin_q + CW'(1);
        len_y = ymax_q - ymin_q + CW'(1);

        if (frame_start) begin
            mode_d = i_mode;
        end

        case (state_q)
            S_WAIT: begin
                if (frame_start) begin
                    fg_cnt_d = '0;
                    state_d  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (frame_start) begin
                    // short frame: drop what was gathered and start over
                    fg_cnt_d = '0;
                    xmin_d   = '0;
                    xmax_d   = '0;
                    ymin_d   = '0;
                    ymax_d   = '0;
                end else begin
                    if (is_fg) begin
                        fg_cnt_d = fg_cnt_q + (2*CW)'(1);
                        if (fg_cnt_q == '0) begin
                            xmin_d = hcnt;
                            xmax_d = hcnt;
                            ymin_d = vcnt;
                            ymax_d = vcnt;
                        end else begin
                            if (hcnt < xmin_q) xmin_d = hcnt;
                            if (hcnt > xmax_q) xmax_d = hcnt;
                            if (vcnt < ymin_q) ymin_d = vcnt;
                            if (vcnt > ymax_q) ymax_d = vcnt;
                        end
                    end
                    if (frame_end) begin
                        state_d = S_RESOLVE;
                    end
                end
            end
            S_RESOLVE: begin
                res_found_d = (fg_cnt_q >= MIN_CNT);
                res_mid_x_d = sum_x[CW:1];
                res_mid_y_d = sum_y[CW:1];
                res_area_d  = {{CW{1'b0}}, len_x} * {{CW{1'b0}}, len_y};
                state_d     = S_PUBLISH;
            end
            S_PUBLISH: begin
                valid_d    = 1'b1;
                found_d    = res_found_q;
                x0_d       = res_found_q ? xmin_q : '0;
                x1_d       = res_found_q ? xmax_q : '0;
                y0_d       = res_found_q ? ymin_q : '0;
                y1_d       = res_found_q ? ymax_q : '0;
                mid_x_d    = res_found_q ? res_mid_x_q : '0;
                mid_y_d    = res_found_q ? res_mid_y_q : '0;
                area_d     = res_found_q ? res_area_q : '0;
                fg_count_d = fg_cnt_q;
                fg_cnt_d   = '0;
                xmin_d     = '0;
                xmax_d     = '0;
                ymin_d     = '0;
                ymax_d     = '0;
                state_d    = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    // Overlay draws the previously published box, never the one being accumulated.
    logic on_row, on_col, on_ctr, draw_box, draw_ctr, paint;

    always_comb begin
        on_row   = ((vcnt == y0_q) || (vcnt == y1_q)) && (hcnt >= x0_q) && (hcnt <= x1_q);
        on_col   = ((hcnt == x0_q) || (hcnt == x1_q)) && (vcnt >= y0_q) && (vcnt <= y1_q);
        on_ctr   = (hcnt == mid_x_q) && (vcnt == mid_y_q);
        draw_box = (mode_q == MODE_BOX) || (mode_q == MODE_BOXC);
        draw_ctr = (mode_q == MODE_BOXC) || (mode_q == MODE_CTR);
        paint    = i_de && found_q &&
                   ((draw_box && (on_row || on_col)) || (draw_ctr && on_ctr));
        data_d   = paint ? BOX_COLOR : i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT;
            mode_q      <= MODE_PASS;
            fg_cnt_q    <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
            res_found_q <= 1'b0;
            res_mid_x_q <= '0;
            res_mid_y_q <= '0;
            res_area_q  <= '0;
            valid_q     <= 1'b0;
            found_q     <= 1'b0;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            mid_x_q     <= '0;
            mid_y_q     <= '0;
            area_q      <= '0;
            fg_count_q  <= '0;
            data_q      <= '0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            fg_cnt_q    <= fg_cnt_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            res_found_q <= res_found_d;
            res_mid_x_q <= res_mid_x_d;
            res_mid_y_q <= res_mid_y_d;
            res_area_q  <= res_area_d;
            valid_q     <= valid_d;
            found_q     <= found_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            mid_x_q     <= mid_x_d;
            mid_y_q     <= mid_y_d;
            area_q      <= area_d;
            fg_count_q  <= fg_count_d;
            data_q      <= data_d;
            hsync_q     <= i_hsync;
            vsync_q     <= i_vsync;
            de_q        <= i_de;
        end
    end

    assign o_data     = data_q;
    assign o_hsync    = hsync_q;
    assign o_vsync    = vsync_q;
    assign o_de       = de_q;
    assign o_valid    = valid_q;
    assign o_found    = found_q;
    assign o_x0       = x0_q;
    assign o_y0       = y0_q;
    assign o_x1       = x1_q;
    assign o_y1       = y1_q;
    assign o_mid_x    = mid_x_q;
    assign o_mid_y    = mid_y_q;
    assign o_area     = area_q;
    assign o_fg_count = fg_count_q;

endmodule

// File: tb/tb_bbox_tracker.sv
// Bench for bbox_tracker on a reduced 40x24 raster: two instances (MIN_PIX 100 and 1)
// share stimulus; frame results are scoreboarded, overlay and timing checked per cycle.
module tb_bbox_tracker;
    import bbox_pkg::*;

    localparam int W = 40, H = 24, DW = 24, CW = 11, HB = 4, MIN_A = 100;
    localparam logic [DW-1:0] FG  = 24'h000000;
    localparam logic [DW-1:0] BOX = 24'hff0000;

    typedef struct packed {
        logic            found;
        logic [CW-1:0]   x0, y0, x1, y1, mx, my;
        logic [2*CW-1:0] area, cnt;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [DW-1:0] i_data;
    logic i_hsync, i_vsync, i_de;
    logic [1:0] i_mode;

    logic [DW-1:0] a_data, b_data;
    logic a_hsync, a_vsync, a_de, a_valid, a_found;
    logic b_hsync, b_vsync, b_de, b_valid, b_found;
    logic [CW-1:0] a_x0, a_y0, a_x1, a_y1, a_mid_x, a_mid_y;
    logic [CW-1:0] b_x0, b_y0, b_x1, b_y1, b_mid_x, b_mid_y;
    logic [2*CW-1:0] a_area, a_fg_count, b_area, b_fg_count;

    always #5 clk = ~clk;

    bbox_tracker #(.IMG_W(W), .IMG_H(H), .DW(DW), .CW(CW), .FG_VAL(FG),
                   .MIN_PIX(MIN_A), .BOX_COLOR(BOX)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_hsync(i_hsync),
        .i_vsync(i_vsync), .i_de(i_de), .i_mode(i_mode),
        .o_data(a_data), .o_hsync(a_hsync), .o_vsync(a_vsync), .o_de(a_de),
        .o_valid(a_valid), .o_found(a_found), .o_x0(a_x0), .o_y0(a_y0),
        .o_x1(a_x1), .o_y1(a_y1), .o_mid_x(a_mid_x), .o_mid_y(a_mid_y),
        .o_area(a_area), .o_fg_count(a_fg_count));

    bbox_tracker #(.IMG_W(W), .IMG_H(H), .DW(DW), .CW(CW), .FG_VAL(FG),
                   .MIN_PIX(1), .BOX_COLOR(BOX)) u_dut_min1 (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_hsync(i_hsync),
        .i_vsync(i_vsync), .i_de(i_de), .i_mode(i_mode),
        .o_data(b_data), .o_hsync(b_hsync), .o_vsync(b_vsync), .o_de(b_de),
        .o_valid(b_valid), .o_found(b_found), .o_x0(b_x0), .o_y0(b_y0),
        .o_x1(b_x1), .o_y1(b_y1), .o_mid_x(b_mid_x), .o_mid_y(b_mid_y),
        .o_area(b_area), .o_fg_count(b_fg_count));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cmp_res(input string tag, input res_t obs, input res_t exp);
        chk({tag, "_found"}, 64'(obs.found), 64'(exp.found));
        chk({tag, "_x0"},    64'(obs.x0),    64'(exp.x0));
        chk({tag, "_y0"},    64'(obs.y0),    64'(exp.y0));
        chk({tag, "_x1"},    64'(obs.x1),    64'(exp.x1));
        chk({tag, "_y1"},    64'(obs.y1),    64'(exp.y1));
        chk({tag, "_mid_x"}, 64'(obs.mx),    64'(exp.mx));
        chk({tag, "_mid_y"}, 64'(obs.my),    64'(exp.my));
        chk({tag, "_area"},  64'(obs.area),  64'(exp.area));
        chk({tag, "_count"}, 64'(obs.cnt),   64'(exp.cnt));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"},  64'(a_data), 64'(0));
        chk({tag, "_flags"}, 64'({a_hsync, a_vsync, a_de, a_valid, a_found}), 64'(0));
        chk({tag, "_box"},   64'({a_x0, a_y0, a_x1, a_y1}), 64'(0));
        chk({tag, "_mid"},   64'({a_mid_x, a_mid_y}), 64'(0));
        chk({tag, "_area"},  64'(a_area), 64'(0));
        chk({tag, "_count"}, 64'(a_fg_count), 64'(0));
    endtask

    // scoreboard of expected frame results, one queue per instance
    res_t q_a[$];
    res_t q_b[$];
    res_t obs_a, obs_b;

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid) begin
                obs_a = {a_found, a_x0, a_y0, a_x1, a_y1, a_mid_x, a_mid_y, a_area, a_fg_count};
                if (q_a.size() == 0) chk("a_spurious_valid", 64'(1), 64'(0));
                else cmp_res("a", obs_a, q_a.pop_front());
            end
            if (b_valid) begin
                obs_b = {b_found, b_x0, b_y0, b_x1, b_y1, b_mid_x, b_mid_y, b_area, b_fg_count};
                if (q_b.size() == 0) chk("b_spurious_valid", 64'(1), 64'(0));
                else cmp_res("b", obs_b, q_b.pop_front());
            end
        end
    end

    // frame content and published-box model for the MIN_A instance
    int nr;
    int rx0[2], rx1[2], ry0[2], ry1[2];
    logic pf;
    int px0, py0, px1, py1, pmx, pmy;
    logic [1:0] fmode;

    task automatic clr_rects();
        nr = 0;
    endtask

    task automatic add_rect(input int x0, input int x1, input int y0, input int y1);
        rx0[nr] = x0; rx1[nr] = x1; ry0[nr] = y0; ry1[nr] = y1;
        nr++;
    endtask

    function automatic logic in_rect(input int h, input int v);
        for (int i = 0; i < nr; i++)
            if (h >= rx0[i] && h <= rx1[i] && v >= ry0[i] && v <= ry1[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic hit(input int h, input int v);
        logic box, ctr;
        box = (fmode == MODE_BOX || fmode == MODE_BOXC) &&
              (((v == py0 || v == py1) && h >= px0 && h <= px1) ||
               ((h == px0 || h == px1) && v >= py0 && v <= py1));
        ctr = (fmode == MODE_BOXC || fmode == MODE_CTR) && h == pmx && v == pmy;
        return pf && (box || ctr);
    endfunction

    function automatic logic [DW-1:0] bgv();
        return DW'($urandom_range(1, 32'h00FF_FFFF));
    endfunction

    function automatic res_t mk(input int cnt, input int xmn, input int xmx,
                                input int ymn, input int ymx, input int minp);
        res_t r;
        r = '0;
        r.cnt = (2*CW)'(cnt);
        if (cnt >= minp) begin
            r.found = 1'b1;
            r.x0 = CW'(xmn); r.x1 = CW'(xmx);
            r.y0 = CW'(ymn); r.y1 = CW'(ymx);
            r.mx = CW'((xmn + xmx) / 2);
            r.my = CW'((ymn + ymx) / 2);
            r.area = (2*CW)'((xmx - xmn + 1) * (ymx - ymn + 1));
        end
        return r;
    endfunction

    task automatic cyc(input logic de, input logic hs, input logic vs,
                       input logic [DW-1:0] d, input logic exp_paint);
        i_de = de; i_hsync = hs; i_vsync = vs; i_data = d;
        @(posedge clk); #1;
        if (!rst_n) begin
            chk_zero("rst_hold");
        end else begin
            chk("o_data", 64'(a_data), 64'(exp_paint ? BOX : d));
            chk("o_timing", 64'({a_hsync, a_vsync, a_de}), 64'({hs, vs, de}));
        end
    endtask

    task automatic frame(input logic [1:0] mode, input int stop_line,
                         input int mchg_line, input logic [1:0] mode2, input int rst_line);
        int cnt, xmn, xmx, ymn, ymx;
        logic full, fg;
        res_t ea, eb;
        cnt = 0; xmn = 0; xmx = 0; ymn = 0; ymx = 0;
        full = (stop_line == H) && (rst_line >= H);
        i_mode = mode;
        cyc(1'b0, 1'b0, 1'b1, bgv(), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, bgv(), 1'b0);
        fmode = mode;
        cyc(1'b0, 1'b0, 1'b0, bgv(), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, bgv(), 1'b0);
        for (int v = 0; v < stop_line; v++) begin
            if (v == mchg_line) i_mode = mode2;
            if (v == rst_line) begin
                rst_n = 1'b0;
                #1;
                chk_zero("rst_async");
                cyc(1'b0, 1'b0, 1'b0, bgv(), 1'b0);
                rst_n = 1'b1;
                pf = 1'b0; px0 = 0; py0 = 0; px1 = 0; py1 = 0; pmx = 0; pmy = 0;
            end
            for (int h = 0; h < W; h++) begin
                fg = in_rect(h, v);
                if (fg) begin
                    if (cnt == 0) begin
                        xmn = h; xmx = h; ymn = v; ymx = v;
                    end else begin
                        if (h < xmn) xmn = h;
                        if (h > xmx) xmx = h;
                        if (v < ymn) ymn = v;
                        if (v > ymx) ymx = v;
                    end
                    cnt++;
                end
                cyc(1'b1, 1'b0, 1'b0, fg ? FG : bgv(), hit(h, v));
            end
            if (full && v == H - 1) begin
                ea = mk(cnt, xmn, xmx, ymn, ymx, MIN_A);
                eb = mk(cnt, xmn, xmx, ymn, ymx, 1);
                q_a.push_back(ea);
                q_b.push_back(eb);
                pf = ea.found;
                px0 = int'(ea.x0); py0 = int'(ea.y0);
                px1 = int'(ea.x1); py1 = int'(ea.y1);
                pmx = int'(ea.mx); pmy = int'(ea.my);
            end
            for (int b = 0; b < HB; b++) begin
                cyc(1'b0, b < 2, 1'b0, bgv(), 1'b0);
                if (full && v == H - 1 && b < 3) begin
                    chk("a_valid_timing", 64'(a_valid), 64'(b == 1));
                    chk("b_valid_timing", 64'(b_valid), 64'(b == 1));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_data = '0; i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0; i_mode = MODE_PASS;
        pf = 1'b0; px0 = 0; py0 = 0; px1 = 0; py1 = 0; pmx = 0; pmy = 0;
        fmode = MODE_PASS;
        nr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, bgv(), 1'b0);

        // 200 px rectangle
        clr_rects(); add_rect(10, 29, 4, 13);
        frame(MODE_PASS, H, H, MODE_PASS, H);
        // exactly MIN_PIX pixels, box overlay of previous result
        clr_rects(); add_rect(0, 9, 14, 23);
        frame(MODE_BOX, H, H, MODE_PASS, H);
        // one below MIN_PIX, box+centre overlay
        clr_rects(); add_rect(30, 38, 0, 10);
        frame(MODE_BOXC, H, H, MODE_PASS, H);
        // single pixel; previous result not found so nothing is drawn
        clr_rects(); add_rect(20, 20, 7, 7);
        frame(MODE_CTR, H, H, MODE_PASS, H);
        // block plus the frame-corner pixel
        clr_rects(); add_rect(5, 14, 5, 14); add_rect(W - 1, W - 1, H - 1, H - 1);
        frame(MODE_BOX, H, H, MODE_PASS, H);
        // short frame: vsync arrives after 12 lines
        clr_rects(); add_rect(0, W - 1, 0, H - 1);
        frame(MODE_BOXC, 12, H, MODE_PASS, H);
        // full frame with i_mode changed mid-frame
        clr_rects(); add_rect(20, 31, 2, 11);
        frame(MODE_BOXC, H, 10, MODE_PASS, H);
        // reset in the middle of a frame
        clr_rects(); add_rect(0, 19, 0, H - 1);
        frame(MODE_BOX, H, H, MODE_PASS, 8);
        // first full frame after reset
        clr_rects(); add_rect(1, 38, 1, 22);
        frame(MODE_BOX, H, H, MODE_PASS, H);
        // empty frame
        clr_rects();
        frame(MODE_BOXC, H, H, MODE_PASS, H);

        repeat (4) cyc(1'b0, 1'b0, 1'b0, bgv(), 1'b0);
        chk("a_results_pending", 64'(q_a.size()), 64'(0));
        chk("b_results_pending", 64'(q_b.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
